// File: rtl/qtu_fmb_gen2.sv
// qtu_fmb_gen2 - Q-table update / find-max-best block for the EER-RL node datapath.
//
// Accepts parsed neighbour packets whose chosen cluster head matches this node's.
// It keeps a neighbour table with insert-or-update by source ID. After each table
// change it scans for the best next hop and computes this node's next Q value.
//
// Ports:
//   clk, nrst              clock, synchronous active-low reset
//   en, iAmDestination     packet strobe; packets are ignored while this node is the CH
//   HB_Reset               heartbeat: synchronous table clear and abort
//   f*                     packet fields from the parser
//   chosenCH, hopsFromCH   this node's CH ID and hop count (hopsFromCH is not used yet)
//   node*, neighborIndex   fields and slot of the best entry
//   neighborCount          number of valid table entries
//   chosenHop, hopValid    best next-hop ID and its qualifier
//   myQValueNext           computed Q value for this node
//   busy, tableFull        status flags
//   QTUFMB_done            one-cycle completion pulse
//
// Optional feature macro: QTU_EVICT_EN. When it is defined, a miss on a full table
// replaces the lowest-Q entry, provided the new Q is strictly higher.
//
// state  | meaning
// IDLE   | waiting for an accepted packet
// LOOKUP | walks every slot; finds the ID match, the lowest free slot and the eviction victim
// WRITE  | updates in place, inserts, evicts, or drops the packet
// SCAN   | walks every valid slot to find the best entry
// CALC   | registers the best entry and the new Q value
// DONE   | raises the completion pulse on exit
module qtu_fmb_gen2 #(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    MAX_NEIGHBORS = 8,
    parameter int                    FRAC_BITS     = 14,
    parameter logic [WORD_WIDTH-1:0] GAMMA         = 16'h2000,
    parameter int                    IDX_W         = $clog2(MAX_NEIGHBORS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  iAmDestination,
    input  logic                  HB_Reset,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fHopsFromCH,
    input  logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [IDX_W-1:0]      neighborIndex,
    output logic [IDX_W:0]        neighborCount,
    output logic [WORD_WIDTH-1:0] chosenHop,
    output logic                  hopValid,
    output logic [WORD_WIDTH-1:0] myQValueNext,
    output logic                  busy,
    output logic                  tableFull,
    output logic                  QTUFMB_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITE, S_SCAN, S_CALC, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NEIGHBORS - 1);

    state_t r_state, w_next;

    logic [MAX_NEIGHBORS-1:0] r_tab_vld;
    logic [WORD_WIDTH-1:0]    r_tab_id  [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_tab_hop [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_tab_q   [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_tab_en  [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_tab_hfc [MAX_NEIGHBORS];

    logic [WORD_WIDTH-1:0] r_pkt_id, r_pkt_hop, r_pkt_q, r_pkt_en, r_pkt_hfc;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_match_found, r_free_found, r_best_found;
    logic [IDX_W-1:0]      r_match_idx, r_free_idx, r_best_idx;
    logic [WORD_WIDTH-1:0] r_best_q, r_best_hfc;

    logic [WORD_WIDTH-1:0] r_node_id, r_node_hop, r_node_en, r_node_q, r_chosen_hop, r_myq;
    logic [IDX_W-1:0]      r_nb_idx;
    logic [IDX_W:0]        r_count;
    logic                  r_hop_valid, r_done;

    logic                  w_accept, w_evict_ok, w_do_write;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [2*WORD_WIDTH-1:0] w_prod;
    logic [2*WORD_WIDTH:0]   w_sum;
    logic [WORD_WIDTH-1:0]   w_qnext;
    logic                    w_unused;

    assign w_unused = ^hopsFromCH;
    assign w_accept = en && !iAmDestination && (fChosenCH == chosenCH);

`ifdef QTU_EVICT_EN
    // Victim is the lowest-Q valid slot. The walk is descending, so the strict
    // compare keeps the highest index when Q values tie.
    logic                  r_ev_found;
    logic [IDX_W-1:0]      r_ev_idx;
    logic [WORD_WIDTH-1:0] r_ev_q;

    always_ff @(posedge clk) begin
        if (!nrst || r_state == S_IDLE) begin
            r_ev_found <= 1'b0;
            r_ev_idx   <= '0;
            r_ev_q     <= '0;
        end else if (r_state == S_LOOKUP && r_tab_vld[r_idx] &&
                     (!r_ev_found || r_tab_q[r_idx] < r_ev_q)) begin
            r_ev_found <= 1'b1;
            r_ev_idx   <= r_idx;
            r_ev_q     <= r_tab_q[r_idx];
        end
    end

    assign w_evict_ok = r_ev_found && (r_pkt_q > r_ev_q);
`else
    assign w_evict_ok = 1'b0;
`endif

    always_comb begin
        w_wr_idx = r_free_idx;
        if (r_match_found)
            w_wr_idx = r_match_idx;
        else if (r_free_found)
            w_wr_idx = r_free_idx;
`ifdef QTU_EVICT_EN
        else
            w_wr_idx = r_ev_idx;
`endif
    end

    assign w_do_write = r_match_found || r_free_found || w_evict_ok;

    // The full-width product keeps every bit that survives the shift, so the
    // saturation check sees any overflow.
    assign w_prod  = (2*WORD_WIDTH)'(r_tab_q[r_best_idx]) * (2*WORD_WIDTH)'(GAMMA);
    assign w_sum   = (2*WORD_WIDTH+1)'(w_prod >> FRAC_BITS)
                   + (2*WORD_WIDTH+1)'(r_tab_en[r_best_idx] >> 2);
    assign w_qnext = (|w_sum[2*WORD_WIDTH:WORD_WIDTH]) ? '1 : w_sum[WORD_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!nrst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP: if (r_idx == '0) w_next = S_WRITE;
            S_WRITE:  w_next = w_do_write ? S_SCAN : S_IDLE;
            S_SCAN:   if (r_idx == '0) w_next = S_CALC;
            S_CALC:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (HB_Reset)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_tab_vld     <= '0;
            r_count       <= '0;
            r_hop_valid   <= 1'b0;
            r_node_id     <= '0;
            r_node_hop    <= '0;
            r_node_en     <= '0;
            r_node_q      <= '0;
            r_nb_idx      <= '0;
            r_chosen_hop  <= '0;
            r_myq         <= '0;
            r_done        <= 1'b0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_best_found  <= 1'b0;
        end else if (HB_Reset) begin
            r_tab_vld    <= '0;
            r_count      <= '0;
            r_hop_valid  <= 1'b0;
            r_node_id    <= '0;
            r_node_hop   <= '0;
            r_node_en    <= '0;
            r_node_q     <= '0;
            r_nb_idx     <= '0;
            r_chosen_hop <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_pkt_id      <= fSourceID;
                    r_pkt_hop     <= fSourceHops;
                    r_pkt_q       <= fQValue;
                    r_pkt_en      <= fEnergyLeft;
                    r_pkt_hfc     <= fHopsFromCH;
                    r_idx         <= LAST_IDX;
                    r_match_found <= 1'b0;
                    r_free_found  <= 1'b0;
                end
                S_LOOKUP: begin
                    if (r_tab_vld[r_idx] && r_tab_id[r_idx] == r_pkt_id) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    // The walk is descending, so the last free slot seen is the lowest one.
                    if (!r_tab_vld[r_idx]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (r_idx != '0)
                        r_idx <= r_idx - IDX_W'(1);
                end
                S_WRITE: begin
                    if (w_do_write) begin
                        r_tab_vld[w_wr_idx] <= 1'b1;
                        r_tab_id[w_wr_idx]  <= r_pkt_id;
                        r_tab_hop[w_wr_idx] <= r_pkt_hop;
                        r_tab_q[w_wr_idx]   <= r_pkt_q;
                        r_tab_en[w_wr_idx]  <= r_pkt_en;
                        r_tab_hfc[w_wr_idx] <= r_pkt_hfc;
                    end
                    if (!r_match_found && r_free_found)
                        r_count <= r_count + (IDX_W+1)'(1);
                    r_idx        <= LAST_IDX;
                    r_best_found <= 1'b0;
                end
                S_SCAN: begin
                    // The walk is descending; '<=' on the hop tie lets the lower index win.
                    if (r_tab_vld[r_idx] && (!r_best_found || r_tab_q[r_idx] > r_best_q ||
                        (r_tab_q[r_idx] == r_best_q && r_tab_hfc[r_idx] <= r_best_hfc))) begin
                        r_best_found <= 1'b1;
                        r_best_idx   <= r_idx;
                        r_best_q     <= r_tab_q[r_idx];
                        r_best_hfc   <= r_tab_hfc[r_idx];
                    end
                    if (r_idx != '0)
                        r_idx <= r_idx - IDX_W'(1);
                end
                S_CALC: begin
                    r_node_id    <= r_tab_id[r_best_idx];
                    r_node_hop   <= r_tab_hop[r_best_idx];
                    r_node_en    <= r_tab_en[r_best_idx];
                    r_node_q     <= r_tab_q[r_best_idx];
                    r_nb_idx     <= r_best_idx;
                    r_chosen_hop <= r_tab_id[r_best_idx];
                    r_hop_valid  <= 1'b1;
                    r_myq        <= w_qnext;
                end
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign nodeID        = r_node_id;
    assign nodeHops      = r_node_hop;
    assign nodeEnergy    = r_node_en;
    assign nodeQValue    = r_node_q;
    assign neighborIndex = r_nb_idx;
    assign neighborCount = r_count;
    assign chosenHop     = r_chosen_hop;
    assign hopValid      = r_hop_valid;
    assign myQValueNext  = r_myq;
    assign busy          = (r_state != S_IDLE);
    assign tableFull     = (r_count == (IDX_W+1)'(MAX_NEIGHBORS));
    assign QTUFMB_done   = r_done;
endmodule
